// File: rtl/elevator_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : elevator_dispatcher_if
// Description : Call/sensor inputs and command/status outputs of the dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface elevator_dispatcher_if #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
);
    logic [FLOORS-1:0]  call_req;
    logic               floor_status;
    logic [1:0]         motion_status;
    logic [FLOOR_W-1:0] current_floor;
    logic               door_open;
    logic [FLOORS-1:0]  pending;
    logic               busy;
    logic               fault;

    modport master (
        output call_req, floor_status,
        input  motion_status, current_floor, door_open, pending, busy, fault
    );

    modport slave (
        input  call_req, floor_status,
        output motion_status, current_floor, door_open, pending, busy, fault
    );
endinterface
`default_nettype wire

// File: rtl/elevator_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : elevator_dispatcher
// Description : SCAN call dispatcher: latches calls, tracks the car position,
//               issues start/stop pulses and times the door-open interval.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_dispatcher #(
    parameter int FLOORS      = 8,
    parameter int FLOOR_W     = 3,
    parameter int DOOR_CYCLES = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    elevator_dispatcher_if.slave bus
);

    localparam int                c_CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_DOOR_LOAD = c_CNT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOORS-1:0] c_ONE     = FLOORS'(1);
    localparam logic [1:0]        c_MOT_NONE = 2'b00;
    localparam logic [1:0]        c_MOT_UP   = 2'b01;
    localparam logic [1:0]        c_MOT_DOWN = 2'b10;
    localparam logic [1:0]        c_MOT_STOP = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DOOR   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_dir;          // 0 = up, 1 = down
    logic [FLOOR_W-1:0] r_floor;
    logic [FLOORS-1:0]  r_pending;
    logic [1:0]         r_motion;
    logic               r_door;
    logic               r_busy;
    logic               r_fault;
    logic               r_stop_owed;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_up_any;
    logic               w_dn_any;
    logic               w_ahead;
    logic               w_behind;
    logic               w_new_dir;
    logic               w_at_end;
    logic               w_here;
    logic               w_hit;
    logic [FLOOR_W-1:0] w_next_floor;
    logic [FLOORS-1:0]  w_cur_oh;
    logic [FLOORS-1:0]  w_next_oh;
    logic [FLOORS-1:0]  w_req;
    logic [FLOORS-1:0]  w_clear;

    always_comb begin
        w_up_any = 1'b0;
        w_dn_any = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (r_pending[i] && (i > int'(r_floor))) w_up_any = 1'b1;
            if (r_pending[i] && (i < int'(r_floor))) w_dn_any = 1'b1;
        end
    end

    assign w_ahead      = r_dir ? w_dn_any : w_up_any;
    assign w_behind     = r_dir ? w_up_any : w_dn_any;
    assign w_new_dir    = w_ahead ? r_dir : ~r_dir;
    assign w_at_end     = (!r_dir && (r_floor == FLOOR_W'(FLOORS - 1))) ||
                          ( r_dir && (r_floor == '0));
    assign w_next_floor = r_dir ? (r_floor - FLOOR_W'(1)) : (r_floor + FLOOR_W'(1));
    assign w_cur_oh     = c_ONE << r_floor;
    assign w_next_oh    = c_ONE << w_next_floor;
    assign w_req        = r_pending | bus.call_req;
    assign w_here       = |(r_pending & w_cur_oh);
    // A call arriving in the same cycle as the car counts as a stop request.
    assign w_hit        = |(w_req & w_next_oh);

    always_comb begin
        w_clear = '0;
        case (r_state)
            IDLE:    if (w_here) w_clear = w_cur_oh;
            MOVING:  if (bus.floor_status && !w_at_end && w_hit) w_clear = w_next_oh;
            DOOR:    w_clear = w_cur_oh;
            default: w_clear = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dir       <= 1'b0;
            r_floor     <= '0;
            r_pending   <= '0;
            r_motion    <= c_MOT_NONE;
            r_door      <= 1'b0;
            r_busy      <= 1'b0;
            r_fault     <= 1'b0;
            r_stop_owed <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_pending   <= w_req & ~w_clear;
            r_motion    <= c_MOT_NONE;
            r_stop_owed <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_here) begin
                        r_state <= DOOR;
                        r_door  <= 1'b1;
                        r_cnt   <= c_DOOR_LOAD;
                        r_busy  <= 1'b1;
                    end else if ((r_motion == c_MOT_NONE) && (w_ahead || w_behind)) begin
                        // Holding off one cycle after a stop keeps command pulses apart.
                        r_dir    <= w_new_dir;
                        r_motion <= w_new_dir ? c_MOT_DOWN : c_MOT_UP;
                        r_state  <= MOVING;
                        r_busy   <= 1'b1;
                    end
                end
                MOVING: begin
                    if (bus.floor_status) begin
                        if (w_at_end) begin
                            r_fault  <= 1'b1;
                            r_motion <= c_MOT_STOP;
                            r_state  <= IDLE;
                            r_busy   <= 1'b0;
                        end else begin
                            r_floor <= w_next_floor;
                            if (w_hit) begin
                                r_state <= DOOR;
                                r_door  <= 1'b1;
                                r_cnt   <= c_DOOR_LOAD;
                                // Arrival right on the start pulse: stop goes out next cycle.
                                if (r_motion == c_MOT_NONE) r_motion    <= c_MOT_STOP;
                                else                        r_stop_owed <= 1'b1;
                            end
                        end
                    end
                end
                DOOR: begin
                    if (r_stop_owed) r_motion <= c_MOT_STOP;
                    if (r_cnt == '0) begin
                        r_door  <= 1'b0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_door  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.motion_status = r_motion;
    assign bus.current_floor = r_floor;
    assign bus.door_open     = r_door;
    assign bus.pending       = r_pending;
    assign bus.busy          = r_busy;
    assign bus.fault         = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_elevator_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_dispatcher
// Description : Directed vector table plus hand sequences for the dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_dispatcher;

    localparam int c_FLOORS = 8;
    localparam int c_DOOR   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    elevator_dispatcher_if #(.FLOORS(c_FLOORS), .FLOOR_W(3)) bus ();

    elevator_dispatcher #(
        .FLOORS     (c_FLOORS),
        .FLOOR_W    (3),
        .DOOR_CYCLES(c_DOOR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] call;
        logic       fs;
        logic [1:0] mot;
        logic [2:0] flr;
        logic       door;
        logic [7:0] pend;
        logic       busy;
        logic       fault;
    } vec_t;

    vec_t tbl [10];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_floor = 0;
    bit   exp_up = 1'b1;
    bit   exp_fault = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] mot, input int flr,
                           input logic door, input logic [7:0] pend, input logic busy,
                           input logic fault);
        chk({tag, ".motion"},  32'(bus.motion_status), 32'(mot));
        chk({tag, ".floor"},   32'(bus.current_floor), 32'(flr));
        chk({tag, ".door"},    32'(bus.door_open),     32'(door));
        chk({tag, ".pending"}, 32'(bus.pending),       32'(pend));
        chk({tag, ".busy"},    32'(bus.busy),          32'(busy));
        chk({tag, ".fault"},   32'(bus.fault),         32'(fault));
    endtask

    // Drive inputs for one cycle; outputs are sampled at the following falling edge.
    task automatic cyc(input logic [7:0] c, input logic f, input logic r);
        bus.call_req     = c;
        bus.floor_status = f;
        rst              = r;
        @(posedge clk);
        @(negedge clk);
        bus.call_req     = '0;
        bus.floor_status = 1'b0;
        rst              = 1'b0;
    endtask

    task automatic travel(input int target, input logic [7:0] pend_after,
                          input logic [7:0] pend_during);
        while (exp_floor != target) begin
            cyc(8'h00, 1'b1, 1'b0);
            exp_floor = exp_up ? exp_floor + 1 : exp_floor - 1;
            if (exp_floor == target) begin
                chk_all("arrive", 2'b11, exp_floor, 1'b1, pend_after, 1'b1, exp_fault);
            end else begin
                chk_all("pass", 2'b00, exp_floor, 1'b0, pend_during, 1'b1, exp_fault);
                cyc(8'h00, 1'b0, 1'b0);
                cyc(8'h00, 1'b0, 1'b0);
                chk_all("cruise", 2'b00, exp_floor, 1'b0, pend_during, 1'b1, exp_fault);
            end
        end
    endtask

    task automatic door_phase(input logic [7:0] pend, input bit poke);
        logic [7:0] here;
        here = 8'h01 << exp_floor;
        for (int j = 1; j < c_DOOR; j++) begin
            if (poke && j == 3)                 cyc(here, 1'b0, 1'b0);
            else if (poke && (j == 5 || j == 9)) cyc(8'h00, 1'b1, 1'b0);
            else                                cyc(8'h00, 1'b0, 1'b0);
            chk_all("door", 2'b00, exp_floor, 1'b1, pend, 1'b1, exp_fault);
        end
        cyc(8'h00, 1'b0, 1'b0);
        chk_all("door_end", 2'b00, exp_floor, 1'b0, pend, 1'b0, exp_fault);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.call_req     = '0;
        bus.floor_status = 1'b0;

        //        rst call   fs  mot    flr   door pend   busy fault
        tbl[0] = '{1'b1, 8'h00, 1'b0, 2'b00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h00, 1'b0, 2'b00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h04, 1'b0, 2'b00, 3'd0, 1'b0, 8'h04, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 2'b01, 3'd0, 1'b0, 8'h04, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 2'b00, 3'd0, 1'b0, 8'h04, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 2'b00, 3'd0, 1'b0, 8'h04, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 2'b00, 3'd1, 1'b0, 8'h04, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 2'b00, 3'd1, 1'b0, 8'h04, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 2'b00, 3'd1, 1'b0, 8'h04, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 2'b11, 3'd2, 1'b1, 8'h00, 1'b1, 1'b0};

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].call, tbl[i].fs, tbl[i].rst);
            chk_all($sformatf("vec%0d", i), tbl[i].mot, int'(tbl[i].flr), tbl[i].door,
                    tbl[i].pend, tbl[i].busy, tbl[i].fault);
        end
        exp_floor = 2;
        door_phase(8'h00, 1'b0);

        // Same-floor call, with a repeat call and stray sensor pulses during DOOR
        cyc(8'h04, 1'b0, 1'b0);
        chk_all("same_pend", 2'b00, 2, 1'b0, 8'h04, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        chk_all("same_open", 2'b00, 2, 1'b1, 8'h00, 1'b1, 1'b0);
        door_phase(8'h00, 1'b1);

        // One floor up to reach floor 3 heading up
        cyc(8'h08, 1'b0, 1'b0);
        chk_all("to3_pend", 2'b00, 2, 1'b0, 8'h08, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        chk_all("to3_start", 2'b01, 2, 1'b0, 8'h08, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        travel(3, 8'h00, 8'h08);
        door_phase(8'h00, 1'b0);

        // SCAN: calls at 5 and 0 from floor 3 going up
        cyc(8'h21, 1'b0, 1'b0);
        chk_all("scan_pend", 2'b00, 3, 1'b0, 8'h21, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        chk_all("scan_up", 2'b01, 3, 1'b0, 8'h21, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        travel(5, 8'h01, 8'h21);
        door_phase(8'h01, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        chk_all("scan_down", 2'b10, 5, 1'b0, 8'h01, 1'b1, 1'b0);
        exp_up = 1'b0;
        // Sensor pulse coincident with the start command is counted
        cyc(8'h00, 1'b1, 1'b0);
        exp_floor = 4;
        chk_all("coincident", 2'b00, 4, 1'b0, 8'h01, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        travel(0, 8'h00, 8'h01);
        door_phase(8'h00, 1'b0);

        // Up to floor 6, then toward 7 with the call lost so the car overruns
        cyc(8'h40, 1'b0, 1'b0);
        chk_all("f6_pend", 2'b00, 0, 1'b0, 8'h40, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        chk_all("f6_flip", 2'b01, 0, 1'b0, 8'h40, 1'b1, 1'b0);
        exp_up = 1'b1;
        cyc(8'h00, 1'b0, 1'b0);
        travel(6, 8'h00, 8'h40);
        door_phase(8'h00, 1'b0);
        cyc(8'h80, 1'b0, 1'b0);
        chk_all("f7_pend", 2'b00, 6, 1'b0, 8'h80, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        chk_all("f7_start", 2'b01, 6, 1'b0, 8'h80, 1'b1, 1'b0);
        force dut.r_pending = 8'h00;
        cyc(8'h00, 1'b0, 1'b0);
        release dut.r_pending;
        chk_all("f7_lost", 2'b00, 6, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        exp_floor = 7;
        chk_all("f7_pass", 2'b00, 7, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        exp_fault = 1'b1;
        chk_all("fault", 2'b11, 7, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0);
        chk_all("fault_hold", 2'b00, 7, 1'b0, 8'h00, 1'b0, 1'b1);

        // Reset while the door is open
        cyc(8'h80, 1'b0, 1'b0);
        chk_all("rd_pend", 2'b00, 7, 1'b0, 8'h80, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0);
        chk_all("rd_open", 2'b00, 7, 1'b1, 8'h00, 1'b1, 1'b1);
        cyc(8'h20, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        exp_floor = 0;
        exp_fault = 1'b0;
        chk_all("rst_door", 2'b00, 0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Stray sensor pulse in IDLE
        cyc(8'h00, 1'b1, 1'b0);
        chk_all("stray_idle", 2'b00, 0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
